// File: rtl/sid_wave_sel.sv
// Waveform selector/shaper: derives tri/saw/pulse/noise from the phase word, ANDs the selected shapes.
// Latency: 2 cycles from waveIn to sampleOut; syncOut 1 cycle after the phase MSB falls.
// Backpressure: ctrlReady drops while a control byte is pending, and rises when that byte becomes active.
// Optional: define WAVE_HOLD_DECAY_EN to let a held sample decay toward zero.
module sid_wave_sel #(
  parameter int ACC_W        = 24,
  parameter int OUT_W        = 12,
  parameter int DECAY_CYCLES = 8192
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] waveIn,
  input  logic [OUT_W-1:0] noiseIn,
  input  logic [OUT_W-1:0] pw,
  input  logic             ringIn,
  input  logic             ctrlValid,
  output logic             ctrlReady,
  input  logic [7:0]       ctrlIn,
  output logic [OUT_W-1:0] sampleOut,
  output logic             sampleValid,
  output logic             syncOut
);

  // Control bytes: [7] noise, [6] pulse, [5] saw, [4] tri, [3:2] reserved, [1] test, [0] ring
  logic [7:0]       act_ctrl;
  logic [7:0]       pend_ctrl;
  logic             pend_full;
  logic             prev_msb;
  logic             wrap;
  logic             accept;
  logic             apply_pend;

  // Stage-1 shapes, plus the control snapshot that travels with them
  logic [OUT_W-1:0] phase;
  logic             tri_inv;
  logic [OUT_W-2:0] tri_half;
  logic [OUT_W-1:0] tri_shape;
  logic [OUT_W-1:0] pulse_shape;
  logic [OUT_W-1:0] s1_saw, s1_tri, s1_pulse, s1_noise;
  logic [3:0]       s1_sel;
  logic             s1_test;
  logic             s1_vld;

  logic [OUT_W-1:0] combined;
  logic             any_sel;

  // Reserved control bits and the fractional phase bits carry no meaning here
  logic             sel_unused;
  assign sel_unused = ^{act_ctrl[3:2], waveIn[ACC_W-OUT_W-1:0]};

  assign wrap      = prev_msb & ~waveIn[ACC_W-1];
  assign ctrlReady = ~pend_full;
  assign accept    = ctrlValid & ~pend_full;
  // A silent or test-mode voice has no audible phase to protect, so it swaps immediately
  assign apply_pend = pend_full &
                      (wrap | (act_ctrl[7:4] == 4'b0000) | act_ctrl[1] | pend_ctrl[1]);

  // Control buffering: new bytes become active only at phase wrap (or at once when harmless)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_ctrl  <= 8'h00;
      pend_ctrl <= 8'h00;
      pend_full <= 1'b0;
    end else if (accept && wrap) begin
      act_ctrl  <= ctrlIn;
    end else if (accept) begin
      pend_ctrl <= ctrlIn;
      pend_full <= 1'b1;
    end else if (apply_pend) begin
      act_ctrl  <= pend_ctrl;
      pend_full <= 1'b0;
    end
  end

  // Wrap detection and the registered hard-sync pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_msb <= 1'b0;
      syncOut  <= 1'b0;
    end else begin
      prev_msb <= waveIn[ACC_W-1];
      syncOut  <= wrap;
    end
  end

  assign phase       = waveIn[ACC_W-1 -: OUT_W];
  assign tri_inv     = phase[OUT_W-1] ^ (act_ctrl[0] & ringIn);
  assign tri_half    = tri_inv ? ~phase[OUT_W-2:0] : phase[OUT_W-2:0];
  assign tri_shape   = {tri_half, 1'b0};
  assign pulse_shape = (act_ctrl[1] || (phase >= pw)) ? '1 : '0;

  // Stage 1: register the raw shapes together with the selection that applies to them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_saw   <= '0;
      s1_tri   <= '0;
      s1_pulse <= '0;
      s1_noise <= '0;
      s1_sel   <= 4'b0000;
      s1_test  <= 1'b0;
      s1_vld   <= 1'b0;
    end else begin
      s1_saw   <= phase;
      s1_tri   <= tri_shape;
      s1_pulse <= pulse_shape;
      s1_noise <= noiseIn;
      s1_sel   <= act_ctrl[7:4];
      s1_test  <= act_ctrl[1];
      s1_vld   <= 1'b1;
    end
  end

  // Combine: AND of all selected shapes; test mode mutes everything but pulse
  always_comb begin
    combined = '1;
    any_sel  = |s1_sel;
    if (s1_sel[3]) combined = combined & s1_noise;
    if (s1_sel[2]) combined = combined & s1_pulse;
    if (s1_sel[1]) combined = combined & s1_saw;
    if (s1_sel[0]) combined = combined & s1_tri;
    if (s1_test && !s1_sel[2]) combined = '0;
  end

`ifdef WAVE_HOLD_DECAY_EN
  localparam int CNT_W = $clog2(DECAY_CYCLES + 1);
  localparam logic [CNT_W-1:0] DECAY_LAST = CNT_W'(DECAY_CYCLES - 1);
  logic [CNT_W-1:0] decay_cnt;
  logic             decay_step;

  assign decay_step = (decay_cnt == DECAY_LAST);

  // Decay timer runs only while the output is floating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decay_cnt <= '0;
    end else if (any_sel || decay_step) begin
      decay_cnt <= '0;
    end else begin
      decay_cnt <= decay_cnt + 1'b1;
    end
  end
`endif

  // Stage 2: output register; with nothing selected the last value floats on the DAC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sampleOut   <= '0;
      sampleValid <= 1'b0;
    end else begin
      sampleValid <= s1_vld;
      if (any_sel) begin
        sampleOut <= combined;
`ifdef WAVE_HOLD_DECAY_EN
      end else if (decay_step) begin
        sampleOut <= sampleOut >> 1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sid_wave_sel.sv
// Bench for sid_wave_sel: directed scenarios with fixed expectations, then a randomized run
// compared against a shape-level reference model.
module tb_sid_wave_sel;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] waveIn = '0;
  logic [11:0] noiseIn = '0;
  logic [11:0] pw = '0;
  logic        ringIn = 1'b0;
  logic        ctrlValid = 1'b0;
  logic        ctrlReady;
  logic [7:0]  ctrlIn = '0;
  logic [11:0] sampleOut;
  logic        sampleValid;
  logic        syncOut;

  int vectors = 0;
  int miscompares = 0;

  sid_wave_sel dut (
    .clk(clk), .rst(rst), .waveIn(waveIn), .noiseIn(noiseIn), .pw(pw),
    .ringIn(ringIn), .ctrlValid(ctrlValid), .ctrlReady(ctrlReady), .ctrlIn(ctrlIn),
    .sampleOut(sampleOut), .sampleValid(sampleValid), .syncOut(syncOut)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_act, m_pend;
  logic        m_pend_full, m_prev, m_sync;
  logic [12:0] m_last;    // {any selected, value} of the shape computed one edge earlier
  logic [11:0] m_sample;
  int          m_vcnt;

  // Shaped value from plain arithmetic on the phase index
  function automatic logic [12:0] shape_of(logic [23:0] w, logic [11:0] nz, logic [11:0] pwv,
                                           logic rin, logic [7:0] c);
    int p, half, tri_v, pulse, val;
    bit inv;
    p     = int'(w >> 12);
    half  = p % 2048;
    inv   = (p >= 2048) ^ (c[0] && rin);
    tri_v = (inv ? 2047 - half : half) * 2;
    pulse = (p >= int'(pwv) || c[1]) ? 4095 : 0;
    val   = 4095;
    if (c[7]) val = val & int'(nz);
    if (c[6]) val = val & pulse;
    if (c[5]) val = val & p;
    if (c[4]) val = val & tri_v;
    if (c[1] && !c[6]) val = 0;
    return {c[7:4] != 4'b0000, 12'(val)};
  endfunction

  task automatic model_reset();
    m_act = 8'h00; m_pend = 8'h00; m_pend_full = 1'b0; m_prev = 1'b0;
    m_sync = 1'b0; m_last = '0; m_sample = '0; m_vcnt = 0;
  endtask

  // Advance the model by one edge using the current inputs, then clock the DUT
  task automatic tick();
    logic wrap, acc;
    logic [12:0] sh;
    if (rst) begin
      model_reset();
    end else begin
      wrap = m_prev && !waveIn[23];
      acc  = ctrlValid && !m_pend_full;
      sh   = shape_of(waveIn, noiseIn, pw, ringIn, m_act);
      if (m_last[12]) m_sample = m_last[11:0];
      m_last = sh;
      if (acc && wrap) m_act = ctrlIn;
      else if (acc) begin
        m_pend = ctrlIn; m_pend_full = 1'b1;
      end else if (m_pend_full && (wrap || m_act[7:4] == 4'b0000 || m_act[1] || m_pend[1])) begin
        m_act = m_pend; m_pend_full = 1'b0;
      end
      m_sync = wrap;
      m_prev = waveIn[23];
      if (m_vcnt < 2) m_vcnt++;
    end
    @(posedge clk);
    #1;
  endtask

  // Reset, then load a control byte into an idle voice (applied on the following edge)
  task automatic setup(input logic [7:0] c);
    rst = 1'b1; ctrlValid = 1'b0; waveIn = '0; noiseIn = '0; pw = '0; ringIn = 1'b0;
    tick(); tick();
    rst = 1'b0;
    ctrlValid = 1'b1; ctrlIn = c;
    tick();
    ctrlValid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vectors++; if (sampleOut !== 12'h000) begin miscompares++; $display("FAIL reset_sample got %h want 000", sampleOut); end
    vectors++; if (sampleValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", sampleValid); end
    vectors++; if (syncOut !== 1'b0) begin miscompares++; $display("FAIL reset_sync got %b want 0", syncOut); end
    vectors++; if (ctrlReady !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", ctrlReady); end
    rst = 1'b0;
    tick();
    vectors++; if (sampleValid !== 1'b0) begin miscompares++; $display("FAIL valid_1st got %b want 0", sampleValid); end
    tick();
    vectors++; if (sampleValid !== 1'b1) begin miscompares++; $display("FAIL valid_2nd got %b want 1", sampleValid); end
  endtask

  task automatic test_saw();
    setup(8'h20);
    waveIn = 24'h123456;
    tick();
    vectors++; if (sampleOut !== 12'h000) begin miscompares++; $display("FAIL saw_lat1 got %h want 000", sampleOut); end
    tick();
    vectors++; if (sampleOut !== 12'h123) begin miscompares++; $display("FAIL saw_lat2 got %h want 123", sampleOut); end
    vectors++; if (sampleValid !== 1'b1) begin miscompares++; $display("FAIL saw_valid got %b want 1", sampleValid); end
  endtask

  task automatic test_tri();
    setup(8'h10);
    waveIn = 24'h9AB000;
    repeat (3) tick();
    vectors++; if (sampleOut !== 12'hCA8) begin miscompares++; $display("FAIL tri got %h want CA8", sampleOut); end
    setup(8'h11);
    waveIn = 24'h9AB000;
    repeat (3) tick();
    vectors++; if (sampleOut !== 12'hCA8) begin miscompares++; $display("FAIL tri_ring0 got %h want CA8", sampleOut); end
    ringIn = 1'b1;
    repeat (3) tick();
    vectors++; if (sampleOut !== 12'h356) begin miscompares++; $display("FAIL tri_ring1 got %h want 356", sampleOut); end
  endtask

  task automatic test_pulse();
    setup(8'h40);
    pw = 12'h800; waveIn = 24'h7FF000;
    repeat (3) tick();
    vectors++; if (sampleOut !== 12'h000) begin miscompares++; $display("FAIL pulse_below got %h want 000", sampleOut); end
    waveIn = 24'h800000;
    repeat (3) tick();
    vectors++; if (sampleOut !== 12'hFFF) begin miscompares++; $display("FAIL pulse_at got %h want FFF", sampleOut); end
    pw = 12'hFFF; waveIn = 24'hFFE000;
    repeat (3) tick();
    vectors++; if (sampleOut !== 12'h000) begin miscompares++; $display("FAIL pulse_pwmax_lo got %h want 000", sampleOut); end
    waveIn = 24'hFFF000;
    repeat (3) tick();
    vectors++; if (sampleOut !== 12'hFFF) begin miscompares++; $display("FAIL pulse_pwmax_hi got %h want FFF", sampleOut); end
    pw = 12'h000; waveIn = 24'h000000;
    repeat (3) tick();
    vectors++; if (sampleOut !== 12'hFFF) begin miscompares++; $display("FAIL pulse_pw0 got %h want FFF", sampleOut); end
    setup(8'h42);
    pw = 12'h800; waveIn = 24'h000000;
    repeat (3) tick();
    vectors++; if (sampleOut !== 12'hFFF) begin miscompares++; $display("FAIL pulse_test got %h want FFF", sampleOut); end
    setup(8'h22);
    waveIn = 24'h123456;
    repeat (3) tick();
    vectors++; if (sampleOut !== 12'h000) begin miscompares++; $display("FAIL test_mute got %h want 000", sampleOut); end
  endtask

  task automatic test_switch_at_wrap();
    int syncs;
    setup(8'h20);
    pw = 12'h800; waveIn = 24'hC00000;
    repeat (3) tick();
    vectors++; if (sampleOut !== 12'hC00) begin miscompares++; $display("FAIL sw_saw got %h want C00", sampleOut); end
    ctrlValid = 1'b1; ctrlIn = 8'h40;
    tick();
    ctrlValid = 1'b0;
    vectors++; if (ctrlReady !== 1'b0) begin miscompares++; $display("FAIL sw_ready_drop got %b want 0", ctrlReady); end
    waveIn = 24'hD00000;
    syncs = 0;
    repeat (4) begin tick(); if (syncOut) syncs++; end
    vectors++; if (sampleOut !== 12'hD00) begin miscompares++; $display("FAIL sw_still_saw got %h want D00", sampleOut); end
    vectors++; if (ctrlReady !== 1'b0) begin miscompares++; $display("FAIL sw_ready_held got %b want 0", ctrlReady); end
    waveIn = 24'h100000;
    tick();
    if (syncOut) syncs++;
    vectors++; if (syncOut !== 1'b1) begin miscompares++; $display("FAIL sw_sync got %b want 1", syncOut); end
    repeat (4) begin tick(); if (syncOut) syncs++; end
    vectors++; if (syncs !== 1) begin miscompares++; $display("FAIL sw_sync_count got %0d want 1", syncs); end
    vectors++; if (sampleOut !== 12'h000) begin miscompares++; $display("FAIL sw_pulse got %h want 000", sampleOut); end
    vectors++; if (ctrlReady !== 1'b1) begin miscompares++; $display("FAIL sw_ready_back got %b want 1", ctrlReady); end
  endtask

  task automatic test_accept_on_wrap();
    setup(8'h20);
    waveIn = 24'hC00000;
    repeat (2) tick();
    ctrlValid = 1'b1; ctrlIn = 8'h40; waveIn = 24'h100000;
    tick();
    ctrlValid = 1'b0;
    vectors++; if (ctrlReady !== 1'b1) begin miscompares++; $display("FAIL aw_ready got %b want 1", ctrlReady); end
    repeat (3) tick();
    vectors++; if (sampleOut !== 12'hFFF) begin miscompares++; $display("FAIL aw_pulse got %h want FFF", sampleOut); end
  endtask

  task automatic test_hold();
    setup(8'h30);
    waveIn = 24'hC00000;
    repeat (3) tick();
    vectors++; if (sampleOut !== 12'h400) begin miscompares++; $display("FAIL hold_and got %h want 400", sampleOut); end
    ctrlValid = 1'b1; ctrlIn = 8'h00;
    tick();
    ctrlValid = 1'b0;
    waveIn = 24'h600000;
    tick();
    repeat (20) begin
      waveIn = 24'($urandom); noiseIn = 12'($urandom);
      tick();
    end
    vectors++; if (sampleOut !== 12'h400) begin miscompares++; $display("FAIL hold_keep got %h want 400", sampleOut); end
`ifdef WAVE_HOLD_DECAY_EN
    repeat (8180) tick();
    vectors++; if (sampleOut !== 12'h200) begin miscompares++; $display("FAIL hold_decay got %h want 200", sampleOut); end
`endif
  endtask

  task automatic test_reset_pending();
    setup(8'h20);
    pw = 12'h000; waveIn = 24'hC00000;
    repeat (2) tick();
    ctrlValid = 1'b1; ctrlIn = 8'h40;
    tick();
    ctrlValid = 1'b0;
    vectors++; if (ctrlReady !== 1'b0) begin miscompares++; $display("FAIL rp_pending got %b want 0", ctrlReady); end
    #2 rst = 1'b1;
    #1;
    model_reset();
    vectors++; if (sampleOut !== 12'h000) begin miscompares++; $display("FAIL rp_sample got %h want 000", sampleOut); end
    vectors++; if (ctrlReady !== 1'b1) begin miscompares++; $display("FAIL rp_ready got %b want 1", ctrlReady); end
    vectors++; if (sampleValid !== 1'b0 || syncOut !== 1'b0) begin miscompares++; $display("FAIL rp_flags got %b%b want 00", sampleValid, syncOut); end
    tick();
    rst = 1'b0;
    repeat (2) tick();
    waveIn = 24'h100000;
    repeat (5) tick();
    vectors++; if (sampleOut !== 12'h000) begin miscompares++; $display("FAIL rp_no_apply got %h want 000", sampleOut); end
    vectors++; if (ctrlReady !== 1'b1) begin miscompares++; $display("FAIL rp_ready_after got %b want 1", ctrlReady); end
  endtask

  task automatic test_random();
    logic [23:0] acc;
    rst = 1'b1; ctrlValid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    acc = 24'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) acc = 24'($urandom);
      else acc = acc + 24'($urandom_range(24'h020000, 24'h300000));
      waveIn    = acc;
      noiseIn   = 12'($urandom);
      ringIn    = 1'($urandom);
      if ($urandom_range(0, 15) == 0) pw = 12'($urandom);
      ctrlValid = ($urandom_range(0, 5) == 0);
      ctrlIn    = 8'($urandom) & (($urandom_range(0, 7) == 0) ? 8'hFF : 8'hFD);
      tick();
      vectors++; if (sampleOut !== m_sample) begin miscompares++; $display("FAIL rnd_sample cyc %0d got %h want %h", i, sampleOut, m_sample); end
      vectors++; if (sampleValid !== (m_vcnt >= 2)) begin miscompares++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, sampleValid, m_vcnt >= 2); end
      vectors++; if (syncOut !== m_sync) begin miscompares++; $display("FAIL rnd_sync cyc %0d got %b want %b", i, syncOut, m_sync); end
      vectors++; if (ctrlReady !== !m_pend_full) begin miscompares++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, ctrlReady, !m_pend_full); end
    end
    ctrlValid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_saw();
    test_tri();
    test_pulse();
    test_switch_at_wrap();
    test_accept_on_wrap();
    test_hold();
    test_reset_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sid_wave_sel.md
Name: sid_wave_sel

Overview:
- Waveform selector/shaper stage directly downstream of the oscillator accumulator.
- Consumes the 24-bit phase word and the 12-bit noise word and derives triangle, sawtooth, pulse and noise shapes.
- ANDs the selected shapes together and emits a registered 12-bit sample for the envelope/DAC path.
- Owns control-register buffering, so waveform changes take effect only at phase wrap, and emits a wrap pulse for hard sync of a neighbouring voice.

Parameters:
- ACC_W, 24, phase input width; shapes are taken from the top 12 bits.
- OUT_W, 12, sample width; fixed relationship OUT_W = 12 in this revision.
- DECAY_CYCLES, 8192, cycles per decay step (used only when WAVE_HOLD_DECAY_EN is defined).

Ports:
- clk  input  1  system clock, 1 MHz voice clock.
- rst  input  1  asynchronous, active-high reset.
- waveIn  input  24  accumulator phase word from the oscillator stage.
- noiseIn  input  12  noise word from the oscillator stage.
- pw  input  12  pulse-width threshold.
- ringIn  input  1  phase MSB of the modulating voice.
- ctrlValid  input  1  new control byte offered.
- ctrlReady  output  1  control byte can be accepted.
- ctrlIn  input  8  control byte: [7] noise, [6] pulse, [5] saw, [4] tri, [3:2] reserved, [1] test, [0] ring.
- sampleOut  output  12  shaped sample.
- sampleValid  output  1  sampleOut holds pipeline data.
- syncOut  output  1  one-cycle pulse on phase wrap.

Behaviour:
- Reset (async, rst=1):
  - active ctrl = 8'h00; pending empty; ctrlReady = 1.
  - sampleOut = 0, sampleValid = 0, syncOut = 0.
  - prevMsb = 0; both pipeline stages cleared.
  - Reset asserted mid-operation discards any pending control byte.
- Wrap detect: wrap = prevMsb & ~waveIn[23]. prevMsb is registered every cycle. syncOut = wrap, registered, so the pulse appears 1 cycle after the MSB falls.
- Control handshake:
  - ctrlReady = ~pending.
  - Accept on ctrlValid & ctrlReady; the byte is stored in pending.
  - Pending is applied to active ctrl at the first wrap. It is applied on the next cycle instead if the active ctrl selects no waveform, or if the test bit is set in the active or pending byte.
  - If accept and wrap occur in the same cycle, the byte goes straight to active ctrl and pending stays empty.
  - Reserved bits are stored but ignored.
- Stage 1 (registered, uses active ctrl). Let p = waveIn[23:12].
  - saw = p.
  - tri = {t, 1'b0}, where t = waveIn[22:12] inverted when (waveIn[23] ^ (ring & ringIn)) = 1.
  - pulse = 12'hFFF if p >= pw, else 12'h000. The test bit forces pulse = 12'hFFF.
  - noise = noiseIn.
- Stage 2 (registered):
  - Combined = bitwise AND of the selected shapes.
  - If test = 1 and pulse is not selected, combined = 0.
  - If no shape is selected, sampleOut holds its last value (DAC float model).
- Latency is 2 cycles from waveIn to sampleOut. sampleValid rises on the 2nd cycle after reset release and then stays high.
- Boundaries:
  - pw = 0 gives pulse always FFF.
  - pw = FFF gives FFF only at p = FFF.
  - waveIn = 0 (oscillator idle) gives saw = 0, tri = 0, pulse = FFF only if pw = 0.

Optional Feature:
- Macro: WAVE_HOLD_DECAY_EN.
- Defined: while no shape is selected, a counter runs, and every DECAY_CYCLES cycles sampleOut shifts right by 1 until it reaches 0. The counter clears whenever any shape is selected or on reset.
- Not defined: the held value persists indefinitely; no counter logic is synthesized.

Test Plan:
- Reset, then ctrl = 8'h20 (saw), waveIn = 24'h123456 -> sampleOut = 12'h123 two cycles later; sampleValid = 1 from the 2nd cycle.
- Tri, waveIn = 24'h9AB000 -> t = ~11'h1AB = 11'h654, sampleOut = 12'hCA8. Same input with ring = 1 and ringIn = 1 -> sampleOut = 12'h356.
- Pulse with pw = 12'h800: waveIn = 24'h7FF000 -> 000; waveIn = 24'h800000 -> FFF. Test bit set -> FFF regardless of waveIn.
- Saw active with phase mid-cycle, offer ctrl = 8'h40 -> ctrlReady drops, output stays saw until waveIn[23] falls 1->0, then pulse; syncOut pulses exactly once, 1 cycle after the fall.
- Saw+tri (8'h30), waveIn = 24'hC00000 -> saw C00 AND tri 7FE = 12'h400. Then ctrl = 8'h00 -> sampleOut holds 400; with WAVE_HOLD_DECAY_EN it becomes 200 after 8192 cycles.
- Assert rst while pending is full -> all outputs 0, ctrlReady = 1, active ctrl 00, pending byte never applied.
